m2_scheduler: RTL and testbench
===============================

M2_SCHEDULER -- requirements
Module: m2_scheduler

Interface
REQ-001 Parameter TOTAL_BLOCKS, default 2400, number of 8x8 blocks processed per run (1200 Y + 600 U + 600 V).
REQ-002 Port CLOCK_50_I  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port Resetn  in  1  asynchronous active-low reset.
REQ-004 Port M2_start  in  1  single-cycle request to begin a run.
REQ-005 Port M2_done  out  1  single-cycle pulse when the whole run has finished.
REQ-006 Port M2_busy  out  1  high whenever the state is not IDLE.
REQ-007 Port FS_start/CT_start/CS_start/WS_start  out  1 each  single-cycle start pulses to fetch-S', compute-T, compute-S and write-S blocks.
REQ-008 Port FS_done/CT_done/CS_done/WS_done  in  1 each  completion from the four sub-blocks; each may be a pulse or a held level.
REQ-009 Port block_index  out  12  index k of the block currently in compute-S/write-S.
REQ-010 Port FS_SRAM_address  in  18  SRAM read address driven by fetch-S'.
REQ-011 Port WS_SRAM_address  in  18, WS_SRAM_write_data  in  16, WS_SRAM_we_n  in  1  write-S SRAM request.
REQ-012 Port SRAM_address  out  18, SRAM_write_data  out  16, SRAM_we_n  out  1  shared SRAM port.

Function
REQ-013 States: IDLE, LI_FS, LI_CT, MEGA_A, MEGA_B, LO_CS, LO_WS, DONE.
REQ-014 IDLE: M2_start=1 -> LI_FS, k<=0, FS_start pulsed on the entry cycle; M2_start outside IDLE is ignored.
REQ-015 Every start pulse is registered, high exactly one cycle, the first cycle the state is occupied (including re-entry of MEGA_A/MEGA_B).
REQ-016 On each start pulse the matching sticky done flag is cleared; thereafter any cycle with X_done=1 sets flag X; a done level present on the start cycle is ignored.
REQ-017 LI_FS: fetch block 0; on FS flag -> LI_CT with CT_start.
REQ-018 LI_CT: compute T of block 0; on CT flag -> LO_CS if TOTAL_BLOCKS=1, else MEGA_A.
REQ-019 MEGA_A: CS_start (block k) and FS_start (block k+1) pulsed in the same cycle; exit only when both flags set, in either order or same cycle -> MEGA_B.
REQ-020 MEGA_B: WS_start (block k) and CT_start (block k+1) pulsed together; when both flags set: k<=k+1; new k = TOTAL_BLOCKS-1 -> LO_CS, else -> MEGA_A.
REQ-021 LO_CS: CS_start for last block; on CS flag -> LO_WS with WS_start.
REQ-022 LO_WS: on WS flag -> DONE.
REQ-023 DONE: M2_done=1 for exactly that cycle, -> IDLE next cycle; M2_start in DONE is ignored.
REQ-024 SRAM owner: FS in LI_FS and MEGA_A; WS in MEGA_B and LO_CS excluded, LO_WS included; none otherwise.
REQ-025 Mux is combinational from the owner: FS -> SRAM_address=FS_SRAM_address, SRAM_we_n=1, write data 0; WS -> all three WS_* passed through; none -> address 0, data 0, we_n=1.
REQ-026 SRAM_we_n is never 0 outside states owned by WS.
REQ-027 block_index = k, 12-bit unsigned, never exceeds TOTAL_BLOCKS-1; no wrap.
REQ-028 Each sub-block receives exactly TOTAL_BLOCKS start pulses per run.

Reset
REQ-029 Resetn=0 asynchronously forces IDLE, k=0, all start pulses 0, all sticky flags 0, M2_done=0, M2_busy=0; SRAM outputs then address 0, data 0, we_n=1.
REQ-030 Reset mid-run aborts without any further start pulse or M2_done; next M2_start after release begins a fresh run at k=0.

Verification
REQ-031 TOTAL_BLOCKS=3, sub-block models done 5 cycles after start -> order FS0, CT0, {CS0,FS1}, {WS0,CT1}, {CS1,FS2}, {WS1,CT2}, CS2, WS2; one M2_done; 3 starts per sub-block.
REQ-032 MEGA_A with FS_done 2 cycles, CS_done 40 cycles after start -> MEGA_B entered the cycle after CS_done, not before; FS_done arriving same cycle as CS_done also accepted.
REQ-033 TOTAL_BLOCKS=1 -> FS0, CT0, CS0, WS0, M2_done; no MEGA states visited.
REQ-034 In MEGA_A drive WS_SRAM_we_n=0, WS address 18'h3FFFF -> SRAM_we_n=1, SRAM_address=FS_SRAM_address; in MEGA_B -> SRAM_we_n=0, address 18'h3FFFF.
REQ-035 Resetn pulsed low during MEGA_B at k=1 -> outputs reset immediately; no M2_done; restart completes full run with block_index 0..TOTAL_BLOCKS-1.
REQ-036 Held-high FS_done from previous block present when FS_start pulses -> ignored; transition waits for a fresh done after the start cycle.

Source files
------------

// File: rtl/m2_scheduler.sv
// Top-level sequencer for the IDCT "milestone 2" pipeline: runs fetch-S', compute-T,
// compute-S and write-S over TOTAL_BLOCKS blocks, overlapping neighbouring blocks in pairs.
module m2_scheduler #(
  parameter int TOTAL_BLOCKS = 2400
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        M2_start,
  output logic        M2_done,
  output logic        M2_busy,
  output logic        FS_start,
  output logic        CT_start,
  output logic        CS_start,
  output logic        WS_start,
  input  logic        FS_done,
  input  logic        CT_done,
  input  logic        CS_done,
  input  logic        WS_done,
  output logic [11:0] block_index,
  input  logic [17:0] FS_SRAM_address,
  input  logic [17:0] WS_SRAM_address,
  input  logic [15:0] WS_SRAM_write_data,
  input  logic        WS_SRAM_we_n,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_LI_FS, S_LI_CT, S_MEGA_A, S_MEGA_B, S_LO_CS, S_LO_WS, S_DONE
  } state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_FS, OWN_WS} owner_t;

  localparam logic [11:0] LAST_K = 12'(TOTAL_BLOCKS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_k;
  logic [11:0] w_k_next;

  logic r_fs_start, r_ct_start, r_cs_start, r_ws_start;
  logic r_fs_flag, r_ct_flag, r_cs_flag, r_ws_flag;
  logic w_fs_seen, w_ct_seen, w_cs_seen, w_ws_seen;
  logic w_enter;
  logic w_fs_start_next, w_ct_start_next, w_cs_start_next, w_ws_start_next;
  owner_t w_owner;

  // A done seen in the start cycle (stale flag or level) belongs to the previous job.
  always_comb begin
    w_fs_seen = ~r_fs_start & (r_fs_flag | FS_done);
    w_ct_seen = ~r_ct_start & (r_ct_flag | CT_done);
    w_cs_seen = ~r_cs_start & (r_cs_flag | CS_done);
    w_ws_seen = ~r_ws_start & (r_ws_flag | WS_done);
  end

  always_comb begin
    w_next   = r_state;
    w_k_next = r_k;
    case (r_state)
      S_IDLE: begin
        if (M2_start) begin
          w_next   = S_LI_FS;
          w_k_next = 12'd0;
        end
      end
      S_LI_FS:  if (w_fs_seen) w_next = S_LI_CT;
      S_LI_CT:  if (w_ct_seen) w_next = (TOTAL_BLOCKS == 1) ? S_LO_CS : S_MEGA_A;
      S_MEGA_A: if (w_cs_seen && w_fs_seen) w_next = S_MEGA_B;
      S_MEGA_B: begin
        if (w_ws_seen && w_ct_seen) begin
          w_k_next = r_k + 12'd1;
          w_next   = (w_k_next == LAST_K) ? S_LO_CS : S_MEGA_A;
        end
      end
      S_LO_CS:  if (w_cs_seen) w_next = S_LO_WS;
      S_LO_WS:  if (w_ws_seen) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Starts fire on every state entry; MEGA_A/MEGA_B only ever re-enter from each other.
  always_comb begin
    w_enter         = (w_next != r_state);
    w_fs_start_next = w_enter && (w_next == S_LI_FS || w_next == S_MEGA_A);
    w_ct_start_next = w_enter && (w_next == S_LI_CT || w_next == S_MEGA_B);
    w_cs_start_next = w_enter && (w_next == S_MEGA_A || w_next == S_LO_CS);
    w_ws_start_next = w_enter && (w_next == S_MEGA_B || w_next == S_LO_WS);
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_IDLE;
      r_k        <= 12'd0;
      r_fs_start <= 1'b0;
      r_ct_start <= 1'b0;
      r_cs_start <= 1'b0;
      r_ws_start <= 1'b0;
      r_fs_flag  <= 1'b0;
      r_ct_flag  <= 1'b0;
      r_cs_flag  <= 1'b0;
      r_ws_flag  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_k        <= w_k_next;
      r_fs_start <= w_fs_start_next;
      r_ct_start <= w_ct_start_next;
      r_cs_start <= w_cs_start_next;
      r_ws_start <= w_ws_start_next;
      r_fs_flag  <= r_fs_start ? 1'b0 : (r_fs_flag | FS_done);
      r_ct_flag  <= r_ct_start ? 1'b0 : (r_ct_flag | CT_done);
      r_cs_flag  <= r_cs_start ? 1'b0 : (r_cs_flag | CS_done);
      r_ws_flag  <= r_ws_start ? 1'b0 : (r_ws_flag | WS_done);
    end
  end

  // LO_CS leaves the bus idle: compute-S of the last block never touches SRAM.
  always_comb begin
    w_owner = OWN_NONE;
    case (r_state)
      S_LI_FS, S_MEGA_A: w_owner = OWN_FS;
      S_MEGA_B, S_LO_WS: w_owner = OWN_WS;
      default:           w_owner = OWN_NONE;
    endcase
  end

  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (w_owner)
      OWN_FS: SRAM_address = FS_SRAM_address;
      OWN_WS: begin
        SRAM_address    = WS_SRAM_address;
        SRAM_write_data = WS_SRAM_write_data;
        SRAM_we_n       = WS_SRAM_we_n;
      end
      default: ;
    endcase
  end

  assign M2_done     = (r_state == S_DONE);
  assign M2_busy     = (r_state != S_IDLE);
  assign FS_start    = r_fs_start;
  assign CT_start    = r_ct_start;
  assign CS_start    = r_cs_start;
  assign WS_start    = r_ws_start;
  assign block_index = r_k;

endmodule

// File: tb/tb_m2_scheduler.sv
// Directed bench for m2_scheduler: a 3-block instance for the pipelined schedule and a
// 1-block instance for the degenerate schedule, driven by simple sub-block latency models.
module tb_m2_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int testsRun = 0;
  int testsFailed = 0;

  // Three-block instance
  logic        Resetn = 1'b1;
  logic        m2Start = 1'b0;
  logic        m2Done, m2Busy, fsStart, ctStart, csStart, wsStart;
  logic        fsPulse = 1'b0, ctDone = 1'b0, csDone = 1'b0, wsDone = 1'b0;
  logic        fsManual = 1'b0;
  bit          fsAuto = 1'b1;
  wire         fsDoneW = fsAuto ? fsPulse : fsManual;
  logic [11:0] blockIndex;
  logic [17:0] fsAddr = 18'h12345, wsAddr = 18'h3FFFF, sramAddr;
  logic [15:0] wsData = 16'hA5C3, sramData;
  logic        wsWeN = 1'b0, sramWeN;

  // One-block instance
  logic        sM2Start = 1'b0;
  logic        sM2Done, sM2Busy, sFsStart, sCtStart, sCsStart, sWsStart;
  logic        sFsDone = 1'b0, sCtDone = 1'b0, sCsDone = 1'b0, sWsDone = 1'b0;
  logic [11:0] sBlockIndex;
  logic [17:0] sSramAddr;
  logic [15:0] sSramData;
  logic        sSramWeN;
  logic [17:0] zeroAddr = 18'd0;
  logic [15:0] zeroData = 16'd0;
  logic        oneWe = 1'b1;

  m2_scheduler #(.TOTAL_BLOCKS(3)) dut (
    .CLOCK_50_I(clock), .Resetn(Resetn), .M2_start(m2Start), .M2_done(m2Done), .M2_busy(m2Busy),
    .FS_start(fsStart), .CT_start(ctStart), .CS_start(csStart), .WS_start(wsStart),
    .FS_done(fsDoneW), .CT_done(ctDone), .CS_done(csDone), .WS_done(wsDone),
    .block_index(blockIndex), .FS_SRAM_address(fsAddr), .WS_SRAM_address(wsAddr),
    .WS_SRAM_write_data(wsData), .WS_SRAM_we_n(wsWeN),
    .SRAM_address(sramAddr), .SRAM_write_data(sramData), .SRAM_we_n(sramWeN)
  );

  m2_scheduler #(.TOTAL_BLOCKS(1)) dutSingle (
    .CLOCK_50_I(clock), .Resetn(Resetn), .M2_start(sM2Start), .M2_done(sM2Done), .M2_busy(sM2Busy),
    .FS_start(sFsStart), .CT_start(sCtStart), .CS_start(sCsStart), .WS_start(sWsStart),
    .FS_done(sFsDone), .CT_done(sCtDone), .CS_done(sCsDone), .WS_done(sWsDone),
    .block_index(sBlockIndex), .FS_SRAM_address(zeroAddr), .WS_SRAM_address(zeroAddr),
    .WS_SRAM_write_data(zeroData), .WS_SRAM_we_n(oneWe),
    .SRAM_address(sSramAddr), .SRAM_write_data(sSramData), .SRAM_we_n(sSramWeN)
  );

  // Sub-block models for the 3-block instance: a start seen on negedge N raises a one-cycle
  // done pulse at negedge N+lat, which the DUT samples on the following rising edge.
  int fsLat = 5, ctLat = 5, csLat = 5, wsLat = 5;
  int fsCnt = 0, ctCnt = 0, csCnt = 0, wsCnt = 0;
  always @(negedge clock) begin
    fsPulse = 1'b0; ctDone = 1'b0; csDone = 1'b0; wsDone = 1'b0;
    if (!Resetn) begin
      fsCnt = 0; ctCnt = 0; csCnt = 0; wsCnt = 0;
    end else begin
      if (fsCnt > 0) begin fsCnt = fsCnt - 1; if (fsCnt == 0) fsPulse = 1'b1; end
      if (ctCnt > 0) begin ctCnt = ctCnt - 1; if (ctCnt == 0) ctDone = 1'b1; end
      if (csCnt > 0) begin csCnt = csCnt - 1; if (csCnt == 0) csDone = 1'b1; end
      if (wsCnt > 0) begin wsCnt = wsCnt - 1; if (wsCnt == 0) wsDone = 1'b1; end
      if (fsStart) fsCnt = fsLat;
      if (ctStart) ctCnt = ctLat;
      if (csStart) csCnt = csLat;
      if (wsStart) wsCnt = wsLat;
    end
  end

  // Same model for the 1-block instance with a fixed 3-cycle latency on every sub-block.
  int sFsCnt = 0, sCtCnt = 0, sCsCnt = 0, sWsCnt = 0;
  always @(negedge clock) begin
    sFsDone = 1'b0; sCtDone = 1'b0; sCsDone = 1'b0; sWsDone = 1'b0;
    if (!Resetn) begin
      sFsCnt = 0; sCtCnt = 0; sCsCnt = 0; sWsCnt = 0;
    end else begin
      if (sFsCnt > 0) begin sFsCnt = sFsCnt - 1; if (sFsCnt == 0) sFsDone = 1'b1; end
      if (sCtCnt > 0) begin sCtCnt = sCtCnt - 1; if (sCtCnt == 0) sCtDone = 1'b1; end
      if (sCsCnt > 0) begin sCsCnt = sCsCnt - 1; if (sCsCnt == 0) sCsDone = 1'b1; end
      if (sWsCnt > 0) begin sWsCnt = sWsCnt - 1; if (sWsCnt == 0) sWsDone = 1'b1; end
      if (sFsStart) sFsCnt = 3;
      if (sCtStart) sCtCnt = 3;
      if (sCsStart) sCsCnt = 3;
      if (sWsStart) sWsCnt = 3;
    end
  end

  // Monitors record every cycle carrying a start pulse as {FS,CT,CS,WS} plus the block index,
  // and count per-sub-block starts and M2_done pulses so tests can diff before/after a run.
  logic [3:0]  patLog [256];
  logic [11:0] idxLog [256];
  int logLen = 0, doneCnt = 0, fsCount = 0, ctCount = 0, csCount = 0, wsCount = 0;
  always @(negedge clock) begin
    if (fsStart | ctStart | csStart | wsStart) begin
      if (logLen < 256) begin
        patLog[logLen] = {fsStart, ctStart, csStart, wsStart};
        idxLog[logLen] = blockIndex;
      end
      logLen = logLen + 1;
    end
    if (fsStart) fsCount = fsCount + 1;
    if (ctStart) ctCount = ctCount + 1;
    if (csStart) csCount = csCount + 1;
    if (wsStart) wsCount = wsCount + 1;
    if (m2Done) doneCnt = doneCnt + 1;
  end

  logic [3:0]  sPatLog [64];
  logic [11:0] sIdxLog [64];
  int sLogLen = 0, sDoneCnt = 0;
  always @(negedge clock) begin
    if (sFsStart | sCtStart | sCsStart | sWsStart) begin
      if (sLogLen < 64) begin
        sPatLog[sLogLen] = {sFsStart, sCtStart, sCsStart, sWsStart};
        sIdxLog[sLogLen] = sBlockIndex;
      end
      sLogLen = sLogLen + 1;
    end
    if (sM2Done) sDoneCnt = sDoneCnt + 1;
  end

  // Pulses M2_start for one cycle on the chosen instance; returns on the entry cycle's negedge.
  task automatic applyStimulus(input bit single);
    @(negedge clock);
    if (single) sM2Start = 1'b1; else m2Start = 1'b1;
    @(negedge clock);
    sM2Start = 1'b0;
    m2Start  = 1'b0;
  endtask

  task automatic applyReset();
    Resetn = 1'b0;
    repeat (2) @(negedge clock);
    Resetn = 1'b1;
    @(negedge clock);
  endtask

  // Reset is asserted before the first rising edge, so the outputs prove the async path.
  task automatic test_reset();
    #1 Resetn = 1'b0;
    #2;
    testsRun++; if (m2Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", m2Busy); end
    testsRun++; if (m2Done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b want 0", m2Done); end
    testsRun++; if ({fsStart, ctStart, csStart, wsStart} !== 4'b0000) begin testsFailed++;
      $display("[TB] FAIL reset_starts: got %b want 0000", {fsStart, ctStart, csStart, wsStart}); end
    testsRun++; if (blockIndex !== 12'd0) begin testsFailed++; $display("[TB] FAIL reset_index: got %0d want 0", blockIndex); end
    testsRun++; if (sramAddr !== 18'd0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h want 0", sramAddr); end
    testsRun++; if (sramData !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h want 0", sramData); end
    testsRun++; if (sramWeN !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_we_n: got %b want 1", sramWeN); end
    testsRun++; if (sM2Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_single_busy: got %b want 0", sM2Busy); end
    @(negedge clock);
    Resetn = 1'b1;
    @(negedge clock);
  endtask

  // Full 3-block schedule, with stray M2_start mid-run and in the DONE cycle.
  task automatic test_full_run();
    logic [3:0]  expPat [8];
    logic [11:0] expIdx [8];
    int base, dBase, fsB, ctB, csB, wsB;
    bit seen;
    expPat = '{4'b1000, 4'b0100, 4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b0010, 4'b0001};
    expIdx = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd1, 12'd2, 12'd2};
    base = logLen; dBase = doneCnt; fsB = fsCount; ctB = ctCount; csB = csCount; wsB = wsCount;
    applyStimulus(1'b0);
    testsRun++; if ({m2Busy, fsStart} !== 2'b11) begin testsFailed++;
      $display("[TB] FAIL full_entry: busy/fs_start got %b want 11", {m2Busy, fsStart}); end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (i == 20) m2Start = 1'b1;
      if (i == 21) m2Start = 1'b0;
      if (m2Done === 1'b1) begin seen = 1'b1; m2Start = 1'b1; end
    end
    testsRun++; if (!seen) begin testsFailed++; $display("[TB] FAIL full_done_timeout: got no M2_done want one within 200 cycles"); end
    @(negedge clock);
    m2Start = 1'b0;
    testsRun++; if ({m2Busy, fsStart, m2Done} !== 3'b000) begin testsFailed++;
      $display("[TB] FAIL done_start_ignored: busy/fs_start/done got %b want 000", {m2Busy, fsStart, m2Done}); end
    @(negedge clock);
    #1;
    testsRun++; if (logLen - base !== 8) begin testsFailed++; $display("[TB] FAIL full_start_cycles: got %0d want 8", logLen - base); end
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (patLog[base + i] !== expPat[i] || idxLog[base + i] !== expIdx[i]) begin testsFailed++;
        $display("[TB] FAIL full_order[%0d]: got pat %b k %0d want pat %b k %0d", i, patLog[base + i], idxLog[base + i], expPat[i], expIdx[i]); end
    end
    testsRun++; if (fsCount - fsB !== 3) begin testsFailed++; $display("[TB] FAIL full_fs_count: got %0d want 3", fsCount - fsB); end
    testsRun++; if (ctCount - ctB !== 3) begin testsFailed++; $display("[TB] FAIL full_ct_count: got %0d want 3", ctCount - ctB); end
    testsRun++; if (csCount - csB !== 3) begin testsFailed++; $display("[TB] FAIL full_cs_count: got %0d want 3", csCount - csB); end
    testsRun++; if (wsCount - wsB !== 3) begin testsFailed++; $display("[TB] FAIL full_ws_count: got %0d want 3", wsCount - wsB); end
    testsRun++; if (doneCnt - dBase !== 1) begin testsFailed++; $display("[TB] FAIL full_done_count: got %0d want 1", doneCnt - dBase); end
  endtask

  // MEGA_A must wait for the slow CS (40 cycles) whether FS finishes early or together with it.
  task automatic test_mega_wait();
    bit found, ctAtWs;
    int gap;
    for (int c = 0; c < 2; c++) begin
      fsLat = (c == 0) ? 2 : 40;
      csLat = 40;
      applyStimulus(1'b0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge clock);
        if ({fsStart, csStart} == 2'b11) found = 1'b1;
      end
      testsRun++; if (!found) begin testsFailed++; $display("[TB] FAIL mega_a_entry[%0d]: got no MEGA_A want entry within 100 cycles", c); end
      gap = 0; ctAtWs = 1'b0;
      for (int i = 1; i <= 60 && gap == 0; i++) begin
        @(negedge clock);
        if (wsStart) begin gap = i; ctAtWs = ctStart; end
      end
      testsRun++; if (gap !== 41) begin testsFailed++; $display("[TB] FAIL mega_b_delay[%0d]: got %0d cycles want 41", c, gap); end
      testsRun++; if (ctAtWs !== 1'b1) begin testsFailed++; $display("[TB] FAIL mega_b_ct_start[%0d]: got %b want 1", c, ctAtWs); end
      applyReset();
    end
    fsLat = 5;
    csLat = 5;
  endtask

  // SRAM ownership checked on every start cycle; WS asks to write (we_n=0) throughout the run.
  task automatic test_sram_mux();
    logic [3:0]  pat;
    logic [17:0] expA;
    logic [15:0] expD;
    logic        expW;
    bit seen;
    int n;
    wsWeN = 1'b0; wsAddr = 18'h3FFFF; wsData = 16'hA5C3; fsAddr = 18'h12345;
    applyStimulus(1'b0);
    seen = 1'b0; n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (i > 0) @(negedge clock);
      if (m2Done === 1'b1) seen = 1'b1;
      pat = {fsStart, ctStart, csStart, wsStart};
      if (pat != 4'b0000) begin
        n++;
        if (pat[3]) begin expA = fsAddr; expD = 16'd0; expW = 1'b1; end
        else if (pat[0]) begin expA = wsAddr; expD = wsData; expW = wsWeN; end
        else begin expA = 18'd0; expD = 16'd0; expW = 1'b1; end
        testsRun++;
        if ({sramAddr, sramData, sramWeN} !== {expA, expD, expW}) begin testsFailed++;
          $display("[TB] FAIL sram_mux[pat %b]: got addr %h data %h we_n %b want addr %h data %h we_n %b",
                   pat, sramAddr, sramData, sramWeN, expA, expD, expW); end
      end
    end
    testsRun++; if (!seen || n != 8) begin testsFailed++; $display("[TB] FAIL sram_run: got done %b after %0d start cycles want 1 after 8", seen, n); end
  endtask

  // Asynchronous abort in MEGA_B at k=1, then a clean restart from block 0.
  task automatic test_reset_midrun();
    logic [11:0] expIdx [8];
    bit found, seen;
    int snapLog, snapDone, base, dBase;
    expIdx = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd1, 12'd2, 12'd2};
    applyStimulus(1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (wsStart && blockIndex == 12'd1) found = 1'b1;
    end
    testsRun++; if (!found || sramWeN !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL abort_reach_mega_b: got found %b we_n %b want found 1 we_n 0", found, sramWeN); end
    #2 Resetn = 1'b0;
    #1;
    testsRun++; if ({m2Busy, m2Done, fsStart, ctStart, csStart, wsStart} !== 6'b000000) begin testsFailed++;
      $display("[TB] FAIL abort_outputs: busy/done/starts got %b want 000000", {m2Busy, m2Done, fsStart, ctStart, csStart, wsStart}); end
    testsRun++; if ({blockIndex, sramAddr, sramWeN} !== {12'd0, 18'd0, 1'b1}) begin testsFailed++;
      $display("[TB] FAIL abort_index_sram: got k %0d addr %h we_n %b want 0 0 1", blockIndex, sramAddr, sramWeN); end
    snapLog = logLen; snapDone = doneCnt;
    repeat (3) @(negedge clock);
    Resetn = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    testsRun++; if (logLen != snapLog || doneCnt != snapDone) begin testsFailed++;
      $display("[TB] FAIL abort_quiet: got %0d starts %0d dones want 0 0", logLen - snapLog, doneCnt - snapDone); end
    base = logLen; dBase = doneCnt;
    applyStimulus(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (m2Done === 1'b1) seen = 1'b1;
    end
    @(negedge clock);
    #1;
    testsRun++; if (!seen || logLen - base !== 8) begin testsFailed++;
      $display("[TB] FAIL restart_run: got done %b with %0d start cycles want 1 with 8", seen, logLen - base); end
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (idxLog[base + i] !== expIdx[i]) begin testsFailed++;
        $display("[TB] FAIL restart_index[%0d]: got %0d want %0d", i, idxLog[base + i], expIdx[i]); end
    end
    testsRun++; if (doneCnt - dBase !== 1) begin testsFailed++; $display("[TB] FAIL restart_done_count: got %0d want 1", doneCnt - dBase); end
  endtask

  // FS_done held from before the run and still high on the start cycle must not count.
  task automatic test_held_done();
    bit saw;
    fsAuto = 1'b0;
    fsManual = 1'b1;
    @(negedge clock);
    applyStimulus(1'b0);
    testsRun++; if (fsStart !== 1'b1) begin testsFailed++; $display("[TB] FAIL held_start: got %b want 1", fsStart); end
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) fsManual = 1'b0;
      if (ctStart) saw = 1'b1;
    end
    testsRun++; if (saw || m2Busy !== 1'b1) begin testsFailed++;
      $display("[TB] FAIL held_ignored: got ct_start %b busy %b want 0 1", saw, m2Busy); end
    fsManual = 1'b1;
    @(negedge clock);
    fsManual = 1'b0;
    testsRun++; if (ctStart !== 1'b1) begin testsFailed++; $display("[TB] FAIL held_fresh: got ct_start %b want 1", ctStart); end
    applyReset();
    fsAuto = 1'b1;
  endtask

  // Single-block run never enters the MEGA states: starts never overlap.
  task automatic test_single();
    logic [3:0] expPat [4];
    int base, dBase;
    bit seen;
    expPat = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    base = sLogLen; dBase = sDoneCnt;
    applyStimulus(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (sM2Done === 1'b1) seen = 1'b1;
    end
    testsRun++; if (!seen) begin testsFailed++; $display("[TB] FAIL single_done_timeout: got no M2_done want one within 100 cycles"); end
    @(negedge clock);
    #1;
    testsRun++; if (sLogLen - base !== 4) begin testsFailed++; $display("[TB] FAIL single_start_cycles: got %0d want 4", sLogLen - base); end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (sPatLog[base + i] !== expPat[i] || sIdxLog[base + i] !== 12'd0) begin testsFailed++;
        $display("[TB] FAIL single_order[%0d]: got pat %b k %0d want pat %b k 0", i, sPatLog[base + i], sIdxLog[base + i], expPat[i]); end
    end
    testsRun++; if (sDoneCnt - dBase !== 1) begin testsFailed++; $display("[TB] FAIL single_done_count: got %0d want 1", sDoneCnt - dBase); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_mega_wait();
    test_sram_mux();
    test_reset_midrun();
    test_held_done();
    test_single();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
